// File: rtl/cpu_pc_seq.sv
// Program-counter sequencer with jumps, a base register and a return-address stack.
// Every output is a register, so there is no combinational path from any input to any output.
module cpu_pc_seq #(
  parameter int AWIDTH      = 8,
  parameter int STACK_DEPTH = 4,
  localparam int SPW        = $clog2(STACK_DEPTH + 1),
  localparam int IDXW       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              pc_ld_i,
  input  logic              jmp_mode_i,
  input  logic [AWIDTH-1:0] base_reg_offset_i,
  input  logic              base_reg_ld_i,
  input  logic [AWIDTH-1:0] base_reg_data_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [AWIDTH-1:0] base_reg_o,
  output logic [SPW-1:0]    sp_o,
  output logic              stack_err_o
);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              err_q, err_d;
  logic [AWIDTH-1:0] stack_q [STACK_DEPTH];

  logic [AWIDTH-1:0] pcInc;
  logic [AWIDTH-1:0] target;
  logic              push;
  logic [IDXW-1:0]   pushIdx;
  logic [IDXW-1:0]   popIdx;

  // The jump target is formed from the base register as it was before this edge.
  assign pcInc   = pc_q + 1'b1;
  assign target  = jmp_mode_i ? (base_q + base_reg_offset_i) : base_reg_offset_i;
  assign pushIdx = IDXW'(sp_q);
  assign popIdx  = IDXW'(sp_q - 1'b1);

  always_comb begin
    pc_d   = pc_q;
    base_d = base_q;
    sp_d   = sp_q;
    err_d  = err_q;
    push   = 1'b0;
    if (en_i) begin
      if (base_reg_ld_i)
        base_d = base_reg_data_i;
      // Return wins over call; a stack fault falls through to a plain increment.
      if (ret_i) begin
        if (sp_q != '0) begin
          pc_d = stack_q[popIdx];
          sp_d = sp_q - 1'b1;
        end else begin
          pc_d  = pcInc;
          err_d = 1'b1;
        end
      end else if (call_i) begin
        if (sp_q != SPW'(STACK_DEPTH)) begin
          push = 1'b1;
          sp_d = sp_q + 1'b1;
          pc_d = target;
        end else begin
          pc_d  = pcInc;
          err_d = 1'b1;
        end
      end else if (pc_ld_i) begin
        pc_d = target;
      end else begin
        pc_d = pcInc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      base_q <= '0;
      sp_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      base_q <= base_d;
      sp_q   <= sp_d;
      err_q  <= err_d;
    end
  end

  // Stack entries carry no reset value; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst)
      stack_q[pushIdx] <= pcInc;
  end

  assign pc_o        = pc_q;
  assign base_reg_o  = base_q;
  assign sp_o        = sp_q;
  assign stack_err_o = err_q;

endmodule

// File: tb/tb_cpu_pc_seq.sv
// Directed self-checking bench for cpu_pc_seq with hand-computed expected values.
module tb_cpu_pc_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       pcLd;
  logic       jmpMode;
  logic [7:0] offset;
  logic       baseLd;
  logic [7:0] baseData;
  logic       call;
  logic       ret;
  logic [7:0] pcOut;
  logic [7:0] baseOut;
  logic [2:0] spOut;
  logic       stackErr;

  int checkCount = 0;
  int passCount  = 0;

  cpu_pc_seq #(.AWIDTH(8), .STACK_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .en_i              (en),
    .pc_ld_i           (pcLd),
    .jmp_mode_i        (jmpMode),
    .base_reg_offset_i (offset),
    .base_reg_ld_i     (baseLd),
    .base_reg_data_i   (baseData),
    .call_i            (call),
    .ret_i             (ret),
    .pc_o              (pcOut),
    .base_reg_o        (baseOut),
    .sp_o              (spOut),
    .stack_err_o       (stackErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic e, input logic ld, input logic mode, input logic [7:0] off,
                               input logic bld, input logic [7:0] bdata, input logic c, input logic r);
    @(negedge clk);
    en = e; pcLd = ld; jmpMode = mode; offset = off;
    baseLd = bld; baseData = bdata; call = c; ret = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [7:0] pc, input logic [2:0] sp, input logic err);
    checkOutput({tag, ".pc"}, 32'(pcOut), 32'(pc));
    checkOutput({tag, ".sp"}, 32'(spOut), 32'(sp));
    checkOutput({tag, ".err"}, 32'(stackErr), 32'(err));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pcLd = 1'b0; jmpMode = 1'b0; offset = '0;
    baseLd = 1'b0; baseData = '0; call = 1'b0; ret = 1'b0;
    #12;
    checkState("reset", 8'h00, 3'd0, 1'b0);
    checkOutput("reset.base", 32'(baseOut), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Free-running increment out of reset
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 0); checkOutput("inc1", 32'(pcOut), 32'h01);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 0); checkOutput("inc2", 32'(pcOut), 32'h02);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 0); checkOutput("inc3", 32'(pcOut), 32'h03);

    // Asynchronous reset mid-cycle, observed before the next rising edge
    #2; rst = 1'b1; en = 1'b0;
    #1; checkOutput("asyncRst.pc", 32'(pcOut), 32'h00);
    @(negedge clk); rst = 1'b0;

    // Wrap at the top of the address space
    applyStimulus(1, 1, 0, 8'hFF, 0, 8'h00, 0, 0); checkOutput("ldFF", 32'(pcOut), 32'hFF);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 0); checkOutput("wrap", 32'(pcOut), 32'h00);

    // Relative jump uses the old base even while the base is loading
    applyStimulus(1, 1, 1, 8'h05, 1, 8'h40, 0, 0);
    checkOutput("relOldBase.pc", 32'(pcOut), 32'h05);
    checkOutput("relOldBase.base", 32'(baseOut), 32'h40);
    applyStimulus(1, 1, 1, 8'h05, 0, 8'h00, 0, 0); checkOutput("relNewBase.pc", 32'(pcOut), 32'h45);

    // Simple call and return
    applyStimulus(1, 1, 0, 8'h10, 0, 8'h00, 0, 0); checkOutput("ld10", 32'(pcOut), 32'h10);
    applyStimulus(1, 0, 0, 8'h80, 0, 8'h00, 1, 0); checkState("call80", 8'h80, 3'd1, 1'b0);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 1); checkState("ret11", 8'h11, 3'd0, 1'b0);

    // Fill the stack, overflow once, then unwind LIFO and underflow once
    applyStimulus(1, 0, 0, 8'h20, 0, 8'h00, 1, 0); checkState("nest1", 8'h20, 3'd1, 1'b0);
    applyStimulus(1, 0, 0, 8'h30, 0, 8'h00, 1, 0); checkState("nest2", 8'h30, 3'd2, 1'b0);
    applyStimulus(1, 0, 0, 8'h40, 0, 8'h00, 1, 0); checkState("nest3", 8'h40, 3'd3, 1'b0);
    applyStimulus(1, 0, 0, 8'h50, 0, 8'h00, 1, 0); checkState("nest4", 8'h50, 3'd4, 1'b0);
    applyStimulus(1, 0, 0, 8'h60, 0, 8'h00, 1, 0); checkState("overflow", 8'h51, 3'd4, 1'b1);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 1); checkState("unwind4", 8'h41, 3'd3, 1'b1);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 1); checkState("unwind3", 8'h31, 3'd2, 1'b1);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 1); checkState("unwind2", 8'h21, 3'd1, 1'b1);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 1); checkState("unwind1", 8'h12, 3'd0, 1'b1);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 1); checkState("underflow", 8'h13, 3'd0, 1'b1);

    // Call from the last address pushes a wrapped return address; call+ret pops only
    applyStimulus(1, 1, 0, 8'hFF, 0, 8'h00, 0, 0); checkOutput("ldFF2", 32'(pcOut), 32'hFF);
    applyStimulus(1, 0, 0, 8'h70, 0, 8'h00, 1, 0); checkState("callWrap", 8'h70, 3'd1, 1'b1);
    applyStimulus(1, 0, 0, 8'h33, 0, 8'h00, 1, 1); checkState("callRet", 8'h00, 3'd0, 1'b1);

    // Stall holds everything even with requests present
    applyStimulus(0, 1, 0, 8'h55, 1, 8'h99, 1, 0);
    checkState("stall", 8'h00, 3'd0, 1'b1);
    checkOutput("stall.base", 32'(baseOut), 32'h40);

    // Only reset clears the sticky error
    @(negedge clk); rst = 1'b1;
    #1; checkState("rstClear", 8'h00, 3'd0, 1'b0);
    checkOutput("rstClear.base", 32'(baseOut), 32'h00);
    @(negedge clk); rst = 1'b0;
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00, 0, 0); checkOutput("postRst", 32'(pcOut), 32'h01);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
